// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU
// MEM stage and the DMA/loader port.
package dmem_arb_pkg;

  localparam int unsigned DMEM_W         = 16;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned BURST_MAX_DEF  = 4;

  typedef enum logic {
    ST_CPU = 1'b0,
    ST_DMA = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU priority with a DMA starvation bound,
// short DMA burst locking, and a pipeline stall whenever the CPU loses a cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned BURST_MAX  = BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DMEM_W-1:0] cpu_addr,
  input  logic [DMEM_W-1:0] cpu_wdata,
  output logic [DMEM_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [DMEM_W-1:0] dma_addr,
  input  logic [DMEM_W-1:0] dma_wdata,
  input  logic              dma_burst,
  output logic              dma_gnt,
  output logic [DMEM_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [DMEM_W-1:0] mem_addr,
  output logic [DMEM_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DMEM_W-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] BURST_LIM  = 4'(BURST_MAX);
  localparam logic       BURST_OK   = (BURST_MAX > 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [3:0]        r_starve_cnt;
  logic [3:0]        w_starve_nxt;
  logic [3:0]        r_beat_cnt;
  logic [3:0]        w_beat_nxt;
  logic              w_dma_win;
  logic [DMEM_W-1:0] r_dma_rdata;
  logic              r_dma_rvalid;

  assign w_dma_win = dma_req & ((r_state == ST_DMA) | ~cpu_req |
                                (r_starve_cnt == STARVE_LIM));

  assign dma_gnt    = w_dma_win;
  assign cpu_stall  = cpu_req & w_dma_win;
  assign cpu_rdata  = mem_rdata;
  assign mem_addr   = w_dma_win ? dma_addr  : cpu_addr;
  assign mem_wdata  = w_dma_win ? dma_wdata : cpu_wdata;
  assign mem_we     = w_dma_win ? dma_we    : (cpu_req & cpu_we);
  assign dma_rdata  = r_dma_rdata;
  assign dma_rvalid = r_dma_rvalid;

  always_comb begin
    w_state_nxt  = r_state;
    w_beat_nxt   = r_beat_cnt;
    w_starve_nxt = '0;
    if (dma_req & ~w_dma_win)
      w_starve_nxt = (r_starve_cnt == STARVE_LIM) ? STARVE_LIM : r_starve_cnt + 4'd1;

    unique case (r_state)
      ST_CPU: begin
        // The entry beat itself counts as the first beat of the burst.
        if (w_dma_win & dma_burst & BURST_OK) begin
          w_state_nxt = ST_DMA;
          w_beat_nxt  = 4'd1;
        end
      end
      ST_DMA: begin
        if (!dma_req || !dma_burst || (r_beat_cnt + 4'd1 == BURST_LIM)) begin
          w_state_nxt = ST_CPU;
          w_beat_nxt  = '0;
        end else begin
          w_beat_nxt  = r_beat_cnt + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_CPU;
      r_starve_cnt <= '0;
      r_beat_cnt   <= '0;
      r_dma_rdata  <= '0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_beat_cnt   <= w_beat_nxt;
      r_dma_rvalid <= w_dma_win & ~dma_we;
      if (w_dma_win & ~dma_we)
        r_dma_rdata <= mem_rdata;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-ported data memory between the CPU MEM stage and a DMA/loader port. The CPU has priority, bounded by a starvation counter. DMA can lock the memory for short bursts. Whenever the CPU loses a cycle, the block raises a pipeline stall. It sits between the EX/MEM register outputs and DataMemory, and drives the freeze input for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- STARVE_MAX, 4: consecutive denied DMA cycles before DMA is forced through (1..15).
- BURST_MAX, 4: maximum granted beats per DMA burst (1..15).
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  MEM stage needs memory this cycle (MemRead | MemWrite).
- cpu_we  in  1  CPU write.
- cpu_addr  in  16  CPU byte address.
- cpu_wdata  in  16  CPU store data (already offset/sign-selected).
- cpu_rdata  out  16  combinational copy of mem_rdata.
- cpu_stall  out  1  freeze the pipeline; the CPU re-presents the same request next cycle.
- dma_req  in  1  DMA request, held until granted.
- dma_we  in  1  DMA write.
- dma_addr  in  16  DMA address.
- dma_wdata  in  16  DMA write data.
- dma_burst  in  1  more beats follow this one.
- dma_gnt  out  1  beat accepted this cycle.
- dma_rdata  out  16  registered read data.
- dma_rvalid  out  1  dma_rdata valid, one-cycle pulse.
- mem_addr / mem_wdata  out  16  to DataMemory.
- mem_we  out  1  to DataMemory memWrite.
- mem_rdata  in  16  DataMemory asynchronous read data.

## Operation
- States: ST_CPU (reset), ST_DMA (burst lock).
- dma_win = dma_req & (state==ST_DMA | !cpu_req | starve_cnt==STARVE_MAX).
- dma_gnt = dma_win; cpu_stall = cpu_req & dma_win.
- Memory mux: dma_win selects dma_addr/dma_wdata and mem_we=dma_we. Otherwise it selects cpu_addr/cpu_wdata and mem_we=cpu_req&cpu_we.
- mem_we is never asserted while both requests are inactive.
- starve_cnt (4-bit):
  - increments, saturating at STARVE_MAX, when dma_req & !dma_win;
  - clears to 0 on dma_win or !dma_req.
- ST_CPU→ST_DMA when dma_win & dma_burst & BURST_MAX>1. beat_cnt is set to 1 on entry.
- In ST_DMA, each granted beat increments beat_cnt. The block returns to ST_CPU when any of the following holds:
  - !dma_req (no grant that cycle);
  - a granted beat has dma_burst=0;
  - a granted beat brings beat_cnt to BURST_MAX.
- After a burst ends, the CPU is not stalled in the next cycle if cpu_req is active. dma_win in ST_CPU then follows the normal rule.
- Read return: on a cycle with dma_win & !dma_we, dma_rdata<=mem_rdata and dma_rvalid<=1. Otherwise dma_rvalid<=0 and dma_rdata holds.
- Reset values: state=ST_CPU, starve_cnt=0, beat_cnt=0, dma_rdata=0, dma_rvalid=0. Combinational outputs follow inputs.
- rst asserted mid-burst: the burst is abandoned. No rvalid is issued the following cycle.

## Timing
- Grant, stall and memory select are combinational within the request cycle; no added latency for the CPU.
- Writes commit on the clk edge that ends the granted cycle.
- DMA read latency is 1 cycle: dma_rvalid rises the edge after dma_gnt.
- Worst-case CPU stall per DMA access sequence: BURST_MAX cycles.
- Worst-case DMA wait under continuous cpu_req: STARVE_MAX+1 cycles.
- Simultaneous cpu_req and dma_req with starve_cnt<STARVE_MAX in ST_CPU: CPU wins, starve_cnt increments.

## Structure
- Package dmem_arb_pkg holds:
  - state encoding (ST_CPU=1'b0, ST_DMA=1'b1);
  - the 16-bit width constant;
  - default STARVE_MAX/BURST_MAX.
- Everything is in a single module; no sub-module is required. The starvation counter and burst counter are inline registers.

## Test plan
- cpu_req=1 continuously, dma_req=1 (single, burst=0), STARVE_MAX=4 -> CPU served cycles 0-3, dma_gnt and cpu_stall in cycle 4, starve_cnt 0 in cycle 5.
- cpu_req=0, DMA write addr 0x0010 data 0xBEEF, then DMA read 0x0010 -> mem_we=1 on the first beat; dma_rvalid=1 one cycle after the second grant with dma_rdata=0xBEEF.
- DMA burst of 6 beats with dma_burst held and BURST_MAX=4, cpu_req=1 -> 4 grants with cpu_stall=1; return to ST_CPU; CPU served next cycle; starvation rule resumes for the remaining beats.
- DMA drops dma_req mid-burst after 2 beats -> state ST_CPU next cycle, no extra grant, cpu_stall=0.
- rst asserted during the second beat of a read burst -> next cycle state=ST_CPU, dma_rvalid=0, dma_rdata=0, counters 0.
- cpu_req=0, dma_req=0 -> mem_we=0, cpu_stall=0, dma_gnt=0 every cycle.
